// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display fetch (absolute priority), CPU write FIFO drain,
// optional clear engine enabled by `define VGA_FB_CLEAR_EN.
module vga_fb_arbiter #(
    parameter int                ADDR_W      = 19,
    parameter int                DATA_W      = 3,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                FB_SIZE     = 307200,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = '0,
    parameter int                LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              in_clock_50MHz,
    input  logic              in_reset_n,
    input  logic              in_disp_req,
    input  logic [ADDR_W-1:0] in_disp_addr,
    output logic [DATA_W-1:0] ou_disp_data,
    output logic              ou_disp_valid,
    input  logic              in_cpu_wr_valid,
    input  logic [ADDR_W-1:0] in_cpu_wr_addr,
    input  logic [DATA_W-1:0] in_cpu_wr_data,
    output logic              ou_cpu_wr_ready,
    output logic [ADDR_W-1:0] ou_mem_addr,
    output logic              ou_mem_we,
    output logic [DATA_W-1:0] ou_mem_wdata,
    input  logic [DATA_W-1:0] in_mem_rdata,
    output logic [LVL_W-1:0]  ou_fifo_level,
    output logic              ou_proto_err,
    input  logic              in_clear,
    output logic              ou_clear_busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {G_IDLE, G_DISP, G_CPU, G_CLR} grant_t;

    grant_t              w_grant, r_grant;
    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr, r_rptr;
    logic [LVL_W-1:0]    r_count, w_count_nxt;
    logic                r_ready;
    logic                w_push, w_pop;
    logic                r_disp_valid;
    logic                r_proto_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                w_clear_busy;
    logic [ADDR_W-1:0]   w_clear_ptr;

`ifdef VGA_FB_CLEAR_EN
    logic                r_clear_busy;
    logic [ADDR_W-1:0]   r_clear_ptr;

    // A start request while busy is dropped; busy falls with the last address issue.
    always_ff @(posedge in_clock_50MHz or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_clear_busy <= 1'b0;
            r_clear_ptr  <= '0;
        end else if (in_clear && !r_clear_busy) begin
            r_clear_busy <= 1'b1;
            r_clear_ptr  <= '0;
        end else if (w_grant == G_CLR) begin
            r_clear_ptr <= r_clear_ptr + 1'b1;
            if (r_clear_ptr == ADDR_W'(FB_SIZE - 1))
                r_clear_busy <= 1'b0;
        end
    end

    assign w_clear_busy = r_clear_busy;
    assign w_clear_ptr  = r_clear_ptr;
`else
    logic w_unused_clear;
    assign w_unused_clear = in_clear;
    assign w_clear_busy   = 1'b0;
    assign w_clear_ptr    = '0;
`endif

    always_comb begin
        w_grant = G_IDLE;
        if (in_disp_req)
            w_grant = G_DISP;
        else if ((r_count != '0) && !w_clear_busy)
            w_grant = G_CPU;
        else if (w_clear_busy)
            w_grant = G_CLR;
    end

    assign w_push = in_cpu_wr_valid && r_ready;
    assign w_pop  = (w_grant == G_CPU);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge in_clock_50MHz) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= in_cpu_wr_addr;
            r_fifo_data[r_wptr] <= in_cpu_wr_data;
        end
    end

    // Ready looks at next occupancy so a push never lands on a full FIFO.
    always_ff @(posedge in_clock_50MHz or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < LVL_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge in_clock_50MHz or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_grant      <= G_IDLE;
            r_disp_valid <= 1'b0;
            r_proto_err  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            r_grant      <= w_grant;
            r_disp_valid <= (r_grant == G_DISP);
            if (in_disp_req && (r_grant == G_DISP))
                r_proto_err <= 1'b1;
            case (w_grant)
                G_DISP: begin
                    r_mem_addr <= in_disp_addr;
                    r_mem_we   <= 1'b0;
                end
                G_CPU: begin
                    r_mem_addr  <= r_fifo_addr[r_rptr];
                    r_mem_wdata <= r_fifo_data[r_rptr];
                    r_mem_we    <= 1'b1;
                end
                G_CLR: begin
                    r_mem_addr  <= w_clear_ptr;
                    r_mem_wdata <= CLEAR_COLOR;
                    r_mem_we    <= 1'b1;
                end
                default: r_mem_we <= 1'b0;
            endcase
        end
    end

    // RAM read data is already registered inside the RAM; only gate it to the valid slot.
    assign ou_disp_data    = r_disp_valid ? in_mem_rdata : '0;
    assign ou_disp_valid   = r_disp_valid;
    assign ou_cpu_wr_ready = r_ready;
    assign ou_mem_addr     = r_mem_addr;
    assign ou_mem_we       = r_mem_we;
    assign ou_mem_wdata    = r_mem_wdata;
    assign ou_fifo_level   = r_count;
    assign ou_proto_err    = r_proto_err;
    assign ou_clear_busy   = w_clear_busy;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a 1-cycle synchronous RAM model.
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic [2:0]  disp_data;
    logic        disp_valid;
    logic        cpu_v;
    logic [18:0] cpu_addr;
    logic [2:0]  cpu_data;
    logic        cpu_rdy;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;
    logic [2:0]  level;
    logic        proto_err;
    logic        clr;
    logic        clr_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] ram [0:1023];

    vga_fb_arbiter #(.FB_SIZE(16)) dut (
        .in_clock_50MHz (clk),
        .in_reset_n     (rst_n),
        .in_disp_req    (disp_req),
        .in_disp_addr   (disp_addr),
        .ou_disp_data   (disp_data),
        .ou_disp_valid  (disp_valid),
        .in_cpu_wr_valid(cpu_v),
        .in_cpu_wr_addr (cpu_addr),
        .in_cpu_wr_data (cpu_data),
        .ou_cpu_wr_ready(cpu_rdy),
        .ou_mem_addr    (mem_addr),
        .ou_mem_we      (mem_we),
        .ou_mem_wdata   (mem_wdata),
        .in_mem_rdata   (mem_rdata),
        .ou_fifo_level  (level),
        .ou_proto_err   (proto_err),
        .in_clear       (clr),
        .ou_clear_busy  (clr_busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr[9:0]];
        if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
    end

    typedef struct {
        logic        dreq;
        logic [18:0] daddr;
        logic        cv;
        logic [18:0] caddr;
        logic [2:0]  cdata;
        logic        e_we;
        logic [18:0] e_addr;
        logic [2:0]  e_wd;
        logic        e_dv;
        logic [2:0]  e_dd;
        logic [2:0]  e_lvl;
        logic        e_rdy;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_addr"},  32'(mem_addr), 0);
        check({tag, " mem_we"},    32'(mem_we), 0);
        check({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, " disp_valid"},32'(disp_valid), 0);
        check({tag, " disp_data"}, 32'(disp_data), 0);
        check({tag, " ready"},     32'(cpu_rdy), 0);
        check({tag, " level"},     32'(level), 0);
        check({tag, " proto_err"}, 32'(proto_err), 0);
        check({tag, " clear_busy"},32'(clr_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] fd [4];
        int k;
        for (int i = 0; i < 1024; i++) ram[i] = 3'h0;
        ram[16] = 3'h5;
        rst_n = 1'b0; disp_req = 0; disp_addr = 0; cpu_v = 0; cpu_addr = 0; cpu_data = 0; clr = 0;

        // Interleaved display fetch and CPU writes, one row per clock.
        vt[0] = '{1'b1, 19'h10,  1'b1, 19'h100, 3'd1, 1'b0, 19'h10,  3'd0, 1'b0, 3'd0, 3'd1, 1'b1};
        vt[1] = '{1'b0, 19'h0,   1'b1, 19'h101, 3'd2, 1'b1, 19'h100, 3'd1, 1'b1, 3'd5, 3'd1, 1'b1};
        vt[2] = '{1'b1, 19'h10,  1'b0, 19'h0,   3'd0, 1'b0, 19'h10,  3'd1, 1'b0, 3'd0, 3'd1, 1'b1};
        vt[3] = '{1'b0, 19'h0,   1'b1, 19'h102, 3'd3, 1'b1, 19'h101, 3'd2, 1'b1, 3'd5, 3'd1, 1'b1};
        vt[4] = '{1'b1, 19'h100, 1'b0, 19'h0,   3'd0, 1'b0, 19'h100, 3'd2, 1'b0, 3'd0, 3'd1, 1'b1};
        vt[5] = '{1'b0, 19'h0,   1'b0, 19'h0,   3'd0, 1'b1, 19'h102, 3'd3, 1'b1, 3'd1, 3'd0, 1'b1};
        vt[6] = '{1'b1, 19'h102, 1'b0, 19'h0,   3'd0, 1'b0, 19'h102, 3'd3, 1'b0, 3'd0, 3'd0, 1'b1};
        vt[7] = '{1'b0, 19'h0,   1'b0, 19'h0,   3'd0, 1'b0, 19'h102, 3'd3, 1'b1, 3'd3, 3'd0, 1'b1};
        vt[8] = '{1'b0, 19'h0,   1'b0, 19'h0,   3'd0, 1'b0, 19'h102, 3'd3, 1'b0, 3'd0, 3'd0, 1'b1};

        // Reset state and ready rising one edge after release.
        step;
        check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        #2 check("ready before edge", 32'(cpu_rdy), 0);
        step;
        check("ready after release", 32'(cpu_rdy), 1);
        check("level after release", 32'(level), 0);

        for (int r = 0; r < 9; r++) begin
            disp_req = vt[r].dreq; disp_addr = vt[r].daddr;
            cpu_v = vt[r].cv; cpu_addr = vt[r].caddr; cpu_data = vt[r].cdata;
            step;
            check($sformatf("vec%0d we", r),    32'(mem_we),     32'(vt[r].e_we));
            check($sformatf("vec%0d addr", r),  32'(mem_addr),   32'(vt[r].e_addr));
            check($sformatf("vec%0d wdata", r), 32'(mem_wdata),  32'(vt[r].e_wd));
            check($sformatf("vec%0d dvalid", r),32'(disp_valid), 32'(vt[r].e_dv));
            check($sformatf("vec%0d ddata", r), 32'(disp_data),  32'(vt[r].e_dd));
            check($sformatf("vec%0d level", r), 32'(level),      32'(vt[r].e_lvl));
            check($sformatf("vec%0d ready", r), 32'(cpu_rdy),    32'(vt[r].e_rdy));
        end
        check("proto_err after spaced reqs", 32'(proto_err), 0);

        // CPU burst with no display traffic drains one write per cycle in order.
        for (int i = 0; i < 4; i++) begin
            cpu_v = 1; cpu_addr = 19'h200 + 19'(i); cpu_data = 3'(i + 1);
            step;
            check($sformatf("burst%0d level", i), 32'(level), 1);
            check($sformatf("burst%0d ready", i), 32'(cpu_rdy), 1);
            if (i > 0) begin
                check($sformatf("burst%0d we", i),    32'(mem_we), 1);
                check($sformatf("burst%0d addr", i),  32'(mem_addr), 32'h200 + 32'(i - 1));
                check($sformatf("burst%0d wdata", i), 32'(mem_wdata), 32'(i));
            end
        end
        cpu_v = 0;
        step;
        check("burst last addr", 32'(mem_addr), 32'h203);
        check("burst last wdata", 32'(mem_wdata), 4);
        check("burst last level", 32'(level), 0);
        step;
        check("burst idle we", 32'(mem_we), 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("burst ram%0d", i), 32'(ram[10'h200 + 10'(i)]), 32'(i + 1));

        // Display held high: FIFO fills to full, proto_err latches, every fetch returns.
        fd[0] = 3'd5; fd[1] = 3'd6; fd[2] = 3'd7; fd[3] = 3'd0;
        for (int i = 0; i < 5; i++) begin
            disp_req = 1; disp_addr = 19'h10;
            cpu_v = (i < 4); cpu_addr = 19'h300 + 19'(i); cpu_data = fd[i % 4];
            step;
            check($sformatf("fill%0d level", i), 32'(level), 32'((i < 4) ? i + 1 : 4));
            check($sformatf("fill%0d ready", i), 32'(cpu_rdy), 32'(i < 3));
            check($sformatf("fill%0d we", i), 32'(mem_we), 0);
            check($sformatf("fill%0d proto", i), 32'(proto_err), 32'(i >= 1));
            check($sformatf("fill%0d dvalid", i), 32'(disp_valid), 32'(i >= 1));
            if (i >= 1) check($sformatf("fill%0d ddata", i), 32'(disp_data), 5);
        end
        disp_req = 0; cpu_v = 0;
        for (int j = 0; j < 4; j++) begin
            step;
            check($sformatf("drain%0d we", j), 32'(mem_we), 1);
            check($sformatf("drain%0d addr", j), 32'(mem_addr), 32'h300 + 32'(j));
            check($sformatf("drain%0d wdata", j), 32'(mem_wdata), 32'(fd[j]));
            check($sformatf("drain%0d level", j), 32'(level), 32'(3 - j));
            check($sformatf("drain%0d ready", j), 32'(cpu_rdy), 1);
            check($sformatf("drain%0d dvalid", j), 32'(disp_valid), 32'(j == 0));
        end
        step;
        check("proto sticky", 32'(proto_err), 1);
        check("post drain we", 32'(mem_we), 0);

        // Reset mid-stream drops the queued write and the in-flight fetch.
        disp_req = 1; disp_addr = 19'h10; cpu_v = 1; cpu_addr = 19'h60; cpu_data = 3'd7;
        step;
        check("pre-reset level", 32'(level), 1);
        #5 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        disp_req = 0; cpu_v = 0;
        step;
        check_all_zero("held reset");
        @(negedge clk); rst_n = 1'b1;
        step;
        check("rerelease ready", 32'(cpu_rdy), 1);
        check("rerelease level", 32'(level), 0);
        check("rerelease dvalid", 32'(disp_valid), 0);
        step;
        check("discarded write we", 32'(mem_we), 0);
        check("discarded dvalid", 32'(disp_valid), 0);

`ifdef VGA_FB_CLEAR_EN
        // Clear with a concurrent CPU write: clear fills 0..15 first, CPU write follows.
        ram[5] = 3'h7;
        clr = 1; cpu_v = 1; cpu_addr = 19'h50; cpu_data = 3'd6;
        step;
        check("clear start busy", 32'(clr_busy), 1);
        check("clear start level", 32'(level), 1);
        clr = 0; cpu_v = 0;
        k = 0;
        for (int t = 0; t < 60 && k < 17; t++) begin
            clr = (t == 5);
            step;
            if (mem_we) begin
                if (k < 16) begin
                    check($sformatf("clr%0d addr", k), 32'(mem_addr), 32'(k));
                    check($sformatf("clr%0d wdata", k), 32'(mem_wdata), 0);
                    check($sformatf("clr%0d level", k), 32'(level), 1);
                    if (k == 14) check("clr14 busy", 32'(clr_busy), 1);
                end else begin
                    check("clr cpu addr", 32'(mem_addr), 32'h50);
                    check("clr cpu wdata", 32'(mem_wdata), 6);
                    check("clr cpu busy", 32'(clr_busy), 0);
                end
                k++;
            end
        end
        clr = 0;
        check("clear write count", 32'(k), 17);
        step;
        check("clear ram5", 32'(ram[5]), 0);
`else
        clr = 1;
        step;
        clr = 0;
        check("clear ignored busy", 32'(clr_busy), 0);
        check("clear ignored we", 32'(mem_we), 0);
        step;
        check("clear ignored busy2", 32'(clr_busy), 0);
        check("clear ignored we2", 32'(mem_we), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
